// File: rtl/image_proc_pkg.sv
// Shared definitions for the image_processor mode path: mode encodings,
// widths and the mode-scheduler FSM state type.
package image_proc_pkg;

  localparam int NUM_MODES_DEFAULT = 4;
  localparam int MODE_W            = $clog2(NUM_MODES_DEFAULT);
  localparam int FRAME_CNT_W       = 16;

  // Datapath mode encodings selected by the output mux
  localparam logic [MODE_W-1:0] MODE_PASS = 2'd0;
  localparam logic [MODE_W-1:0] MODE_GRAY = 2'd1;
  localparam logic [MODE_W-1:0] MODE_LBP  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_EDGE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Raw key conditioner: 2-FF synchronizer, stable-sample debouncer and a
// one-cycle pulse on each rising edge of the debounced level.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous key into the clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // Flip the level after DEBOUNCE_CYCLES consecutive samples that differ
  // from it; any sample equal to the level restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mode_scheduler.sv
// Mode scheduler for the VGA stream: key requests move a pending target,
// and the target is committed to oMode only at a frame boundary (falling
// edge of iFrameValid), so a frame never mixes two modes.
// Optional feature macro: AUTO_CYCLE_EN (frame-divided automatic Next).
//
// Output protocol: oSwitch is a one-cycle strobe that is high exactly on
// the cycle oMode shows a newly committed value; there is no back-pressure,
// consumers must sample oMode whenever oSwitch is high.
module stream_mode_scheduler
  import image_proc_pkg::*;
#(
  parameter int NUM_MODES       = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_FRAMES     = 60
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iNextKey,
  input  logic                          iPrevKey,
  input  logic                          iFrameValid,
  input  logic                          iAuto,
  output logic [$clog2(NUM_MODES)-1:0]  oMode,
  output logic [$clog2(NUM_MODES)-1:0]  oTarget,
  output logic                          oPending,
  output logic                          oSwitch,
  output logic [FRAME_CNT_W-1:0]        oFrameCount,
  output sched_state_t                  oState
);

  localparam int MW = $clog2(NUM_MODES);
  localparam logic [MW-1:0] MODE_LAST = MW'(NUM_MODES - 1);

  logic          key_next;
  logic          key_prev;
  logic          req_next;
  logic          req_prev;
  logic          fv_q;
  logic          fe;
  logic [MW-1:0] target_nxt;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_next_key (
    .clk  (iClk),
    .rst  (iRst),
    .key  (iNextKey),
    .rise (key_next)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_prev_key (
    .clk  (iClk),
    .rst  (iRst),
    .key  (iPrevKey),
    .rise (key_prev)
  );

  // Previous frame-valid sample for boundary detection
  always_ff @(posedge iClk) begin
    if (iRst) fv_q <= 1'b0;
    else      fv_q <= iFrameValid;
  end

  assign fe = fv_q & ~iFrameValid;

`ifdef AUTO_CYCLE_EN
  localparam int DIV_W = $clog2(AUTO_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_FRAMES - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             auto_hit;

  assign auto_hit = iAuto & fe & (div_cnt == DIV_LAST);

  // Count frame boundaries while auto-cycling; held at zero when disabled
  always_ff @(posedge iClk) begin
    if (iRst || !iAuto) begin
      div_cnt <= '0;
    end else if (fe) begin
      if (auto_hit) div_cnt <= '0;
      else          div_cnt <= div_cnt + 1'b1;
    end
  end

  assign req_next = key_next | auto_hit;
`else
  logic unused_auto;
  localparam int unused_auto_frames = AUTO_FRAMES;
  assign unused_auto = iAuto;
  assign req_next    = key_next;
`endif

  assign req_prev = key_prev;

  // Next target: simultaneous next and prev cancel each other
  always_comb begin
    target_nxt = oTarget;
    if (req_next && !req_prev) begin
      target_nxt = (oTarget == MODE_LAST) ? '0 : oTarget + 1'b1;
    end else if (req_prev && !req_next) begin
      target_nxt = (oTarget == '0) ? MODE_LAST : oTarget - 1'b1;
    end
  end

  // Scheduler FSM with registered outputs. On a boundary the commit takes
  // the target as it stood before this cycle's request, which is still
  // applied to oTarget and re-evaluated from IDLE afterwards.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oState      <= IDLE;
      oMode       <= '0;
      oTarget     <= '0;
      oPending    <= 1'b0;
      oSwitch     <= 1'b0;
      oFrameCount <= '0;
    end else begin
      oTarget <= target_nxt;
      oSwitch <= 1'b0;
      if (fe) oFrameCount <= oFrameCount + 1'b1;
      case (oState)
        IDLE: begin
          if (target_nxt != oMode) begin
            oState   <= PENDING;
            oPending <= 1'b1;
          end
        end
        PENDING: begin
          if (fe) begin
            oState   <= COMMIT;
            oMode    <= oTarget;
            oSwitch  <= 1'b1;
            oPending <= 1'b0;
          end else if (target_nxt == oMode) begin
            oState   <= IDLE;
            oPending <= 1'b0;
          end
        end
        COMMIT: begin
          oState   <= IDLE;
          oPending <= 1'b0;
        end
        default: begin
          oState   <= IDLE;
          oPending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/stream_mode_scheduler.md
Name: stream_mode_scheduler

Overview:
Selects which image_processor datapath mode drives the VGA stream: passthrough, grayscale, LBP or edge. Takes debounced next/prev key requests and holds each request as pending. Commits the new mode only at a frame boundary, so no frame ever mixes two modes. Sits beside image_processor; its oMode drives the output-select mux, and its frame count feeds the debug display.

Parameters:
NUM_MODES, 4, number of selectable modes (2..16); MODE_W = clog2(NUM_MODES)
DEBOUNCE_CYCLES, 500000, stable-input cycles needed before a key level is accepted (10 ms at 50 MHz)
AUTO_FRAMES, 60, frames between automatic advances (used only with the optional feature)

Ports:
iClk  input  1  pixel/system clock, all logic on rising edge
iRst  input  1  synchronous reset, active-high
iNextKey  input  1  raw key, 1 = pressed, asynchronous to iClk
iPrevKey  input  1  raw key, 1 = pressed, asynchronous to iClk
iFrameValid  input  1  frame-valid from the camera stream
iAuto  input  1  auto-cycle enable (ignored unless AUTO_CYCLE_EN is defined)
oMode  output  MODE_W  currently committed mode
oTarget  output  MODE_W  pending target mode
oPending  output  1  high while oTarget != oMode
oSwitch  output  1  one-cycle strobe on the cycle oMode changes
oFrameCount  output  16  count of completed frames, wraps at 65535 -> 0

Behaviour:
- Reset (iRst=1 at an edge): oMode=0, oTarget=0, oPending=0, oSwitch=0, oFrameCount=0; FSM=IDLE; debouncers cleared to "released"; frame-edge register cleared to 0.
- Keys: 2-FF synchronizer, then debouncer. The debouncer output follows the input only after DEBOUNCE_CYCLES consecutive equal samples. A rising edge of the debounced level gives a 1-cycle request (reqNext/reqPrev). Holding a key does not auto-repeat.
- Frame boundary fe: iFrameValid registered; fe = prev & ~iFrameValid (falling edge). fe is valid one cycle after the falling edge.
- oFrameCount increments on every fe, including a switch cycle.
- Target update, every cycle:
  - reqNext only: oTarget = (oTarget+1) mod NUM_MODES
  - reqPrev only: oTarget = oTarget-1, wrapping 0 -> NUM_MODES-1
  - both, or neither: unchanged
- FSM:
  - IDLE: oPending=0. Any target update that makes target != mode -> PENDING.
  - PENDING: oPending=1. If target returns to equal mode (e.g. next then prev) -> IDLE with no switch. On fe -> COMMIT.
  - COMMIT: one cycle; oMode <= oTarget; oSwitch=1 for exactly this cycle; -> IDLE.
- A request arriving in the same cycle as fe while in PENDING: the commit uses the target value before the update. The new request is applied to oTarget in that cycle, and the FSM re-enters PENDING from IDLE on the following cycle if target != mode.
- A request during COMMIT updates oTarget and is evaluated in IDLE on the next cycle; it is never lost.
- Latency: fe to oMode change is 1 cycle, so oMode is stable at least 2 cycles before the next frame's first valid pixel.
- Reset mid-frame: everything returns to reset values. The first fe after reset counts as a normal boundary.
- oMode never changes while iFrameValid=1.

Optional Feature:
AUTO_CYCLE_EN
- Defined: a frame divider counts fe while iAuto=1. When the count reaches AUTO_FRAMES it clears and issues a synthetic reqNext, ORed with the key requests; simultaneous-event rules apply, so auto + prev cancel. iAuto=0 holds the divider at 0.
- Undefined: no divider, iAuto unused, behaviour is identical to iAuto=0.

Decomposition:
- Shared package image_proc_pkg:
  - mode encoding constants MODE_PASS=0, MODE_GRAY=1, MODE_LBP=2, MODE_EDGE=3
  - MODE_W
  - FSM state typedef {IDLE, PENDING, COMMIT}
  - FRAME_CNT_W=16
- One sub-module, key_debouncer (synchronizer, stable counter, rising-edge pulse), instantiated twice. Parameter: DEBOUNCE_CYCLES.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, frames of 20 valid cycles plus 5 blank.
- Reset, press Next (held 10 cycles) mid-frame -> oTarget=1 and oPending=1 at once; oMode stays 0 until 1 cycle after FV falls; then oMode=1, oSwitch pulses 1 cycle, oFrameCount=1.
- Prev from mode 0 -> oTarget=3; after the boundary oMode=3. Then Next twice within one frame -> oTarget=1 (wrap), single switch at the boundary.
- Next then Prev in the same frame -> oPending 1 then 0; no oSwitch at the boundary; oMode unchanged.
- Bounce: toggle iNextKey every 2 cycles for 12 cycles -> no request. Then hold high 6 cycles -> exactly one request.
- Next and Prev debounced edges in the same cycle -> oTarget unchanged, FSM stays IDLE.
- Reset asserted mid-PENDING -> all outputs 0 the next cycle, no switch at the following boundary. With AUTO_CYCLE_EN and iAuto=1 -> oMode advances 0→1→2 every 3 frames.
